bus_client_gen: RTL and testbench
=================================

Name: bus_client_gen

Overview:
Parametrised bus-arbiter client and traffic generator, the next generation of the team's fixed-pattern client. It issues request/acknowledge transactions to the arbiter over a programmable address window, with run-time mode selection (write, read, write-then-read check) and programmable inter-request spacing. It adds read-back checking, ack timeout, and transaction/error counters for arbiter soak tests.

Parameters:
DATA_WIDTH, 8, width of dataW/dataR
ADDR_WIDTH, 4, width of address
ADDR_SPACE_BEGINNING, 0, first address of window
ADDR_SPACE_END, 3, last address of window (inclusive, >= BEGINNING)
REQUEST_DELAY, 10, idle cycles between transactions (>= 1)
DATA_SEED, 1, first write data value
TIMEOUT, 64, max cycles rq may stay high without ack (>= 2)
CNT_WIDTH, 16, width of txn_cnt

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
en  in  1  run enable
mode  in  2  00 write-only, 01 read-only, 10 write-then-read check, 11 reserved (treated as 00)
address  out  ADDR_WIDTH  transaction address
rq  out  1  request to arbiter
ack  in  1  acknowledge from arbiter/server
wr_ni  out  1  1 = read, 0 = write
dataW  out  DATA_WIDTH  write data
dataR  in  DATA_WIDTH  read data
txn_cnt  out  CNT_WIDTH  completed transactions, wraps
err_cnt  out  8  read mismatches, saturates at 255
err_flag  out  1  sticky: any mismatch since reset
timeout  out  1  sticky: any ack timeout since reset

Behaviour:
- Reset (reset=0, async): state IDLE; rq=0, wr_ni=0, address=ADDR_SPACE_BEGINNING, dataW=DATA_SEED, txn_cnt=0, err_cnt=0, err_flag=0, timeout=0; internal delay/timeout counters 0. Reset mid-transaction drops rq immediately.
- FSM states: IDLE, DELAY, REQ.
- IDLE: en=1 at edge -> DELAY, delay counter=0. en=0 -> stay.
- DELAY: counter increments each edge; at edge where counter==REQUEST_DELAY-1 -> REQ, rq=1. mode, wr_ni, address, dataW are set up on this same edge. First rq rises REQUEST_DELAY+1 edges after en first sampled high. ack ignored in DELAY. en=0 in DELAY -> IDLE.
- Transaction type chosen entering REQ: mode 00/11 write; 01 read; 10 write if pair phase=0, else read at the same address. The pair phase toggles only on completion.
- REQ: address, wr_ni, dataW held stable while rq=1. Edge with ack=1 = completion: rq=0 next cycle, txn_cnt+1, -> DELAY (counter=0), or -> IDLE if en=0. en=0 never aborts an open request.
- On a read completion, dataR is sampled on the ack edge. In mode 10 it is compared with the value written in phase 0 of the pair. Mismatch: err_cnt+1 (saturating), err_flag=1. No check in mode 01.
- Write completion: dataW increments by 1, wrapping mod 2^DATA_WIDTH, visible on the next write.
- Address advance, after completion: modes 00/01/11 every transaction; mode 10 only after the read phase. address==ADDR_SPACE_END -> ADDR_SPACE_BEGINNING, else +1. The address never leaves the window.
- Timeout: timeout counter runs while in REQ. Reaching TIMEOUT with no ack: rq=0, timeout=1, -> DELAY. No counters, data, address or phase change; the same transaction is retried. ack and timeout on the same edge: ack wins.
- mode changes are honoured only when entering REQ. In mode 10 an in-progress pair (phase=1) completes its read before the new mode applies.
- ack high outside REQ has no effect.

Test Plan:
- Reset/idle: reset=0 then 1, en=0 for 50 cycles -> rq=0, address=0, dataW=1, all counters 0.
- Write walk: mode=00, en=1, ack returned 2 cycles after rq -> first rq 11 edges after en. Addresses 0,1,2,3,0 with dataW 1,2,3,4,5. rq drops the cycle after ack. txn_cnt=5.
- Write-then-read pass/fail: mode=10, server echoes correctly -> addresses 0,0,1,1 with wr_ni 0,1,0,1 and err_cnt=0. Corrupt the 2nd read (dataR=0xFF) -> err_cnt=1, err_flag=1.
- Timeout/retry: TIMEOUT=64, withhold ack on 1st request -> rq falls after 64 cycles, timeout=1. Retry uses the same address 0 and dataW 1. Ack it -> txn_cnt=1.
- en drop mid-request: deassert en while rq=1, ack 5 cycles later -> transaction completes, FSM IDLE, no further rq.
- Async reset mid-REQ: reset=0 with rq=1 -> rq=0 immediately without a clock edge; after release, counters are 0 and the sequence restarts at address 0.

Source files
------------

// File: rtl/bus_client_gen.sv
// bus_client_gen: arbiter client generating write/read/check traffic over an address window
module bus_client_gen #(
  parameter int DATA_WIDTH           = 8,
  parameter int ADDR_WIDTH           = 4,
  parameter int ADDR_SPACE_BEGINNING = 0,
  parameter int ADDR_SPACE_END       = 3,
  parameter int REQUEST_DELAY        = 10,
  parameter int DATA_SEED            = 1,
  parameter int TIMEOUT              = 64,
  parameter int CNT_WIDTH            = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [1:0]            mode,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  rq,
  input  logic                  ack,
  output logic                  wr_ni,
  output logic [DATA_WIDTH-1:0] dataW,
  input  logic [DATA_WIDTH-1:0] dataR,
  output logic [CNT_WIDTH-1:0]  txn_cnt,
  output logic [7:0]            err_cnt,
  output logic                  err_flag,
  output logic                  timeout
);
  localparam int DW = $clog2(REQUEST_DELAY + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, DELAY, REQ} state_t;
  state_t state, state_nx;
  logic [DW-1:0] dly_cnt;
  logic [TW-1:0] to_cnt;
  logic phase, pair, done, expired, go_req;
  logic [ADDR_WIDTH-1:0] addr_nx;
  assign rq      = state == REQ;
  assign done    = state == REQ && ack;
  assign expired = state == REQ && !ack && to_cnt == TW'(TIMEOUT - 1);
  assign go_req  = state == DELAY && en && dly_cnt == DW'(REQUEST_DELAY - 1);
  assign addr_nx = address == ADDR_WIDTH'(ADDR_SPACE_END) ? ADDR_WIDTH'(ADDR_SPACE_BEGINNING)
                                                          : address + 1'b1;
  // state register; reset drops rq at once since rq decodes REQ
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  // next state: en only gates starting work, never aborts an open request
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE  ? (en ? DELAY : IDLE) :
               state == DELAY ? (!en ? IDLE : go_req ? REQ : DELAY) :
               state == REQ   ? (done ? (en ? DELAY : IDLE) : expired ? DELAY : REQ) : IDLE;
  end
  // counters, transaction setup on REQ entry, completion bookkeeping
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      dly_cnt  <= '0;
      to_cnt   <= '0;
      phase    <= 1'b0;
      pair     <= 1'b0;
      wr_ni    <= 1'b0;
      address  <= ADDR_WIDTH'(ADDR_SPACE_BEGINNING);
      dataW    <= DATA_WIDTH'(DATA_SEED);
      txn_cnt  <= '0;
      err_cnt  <= '0;
      err_flag <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      dly_cnt <= state == DELAY ? dly_cnt + 1'b1 : '0;
      to_cnt  <= state == REQ && !ack ? to_cnt + 1'b1 : '0;
      if (expired) timeout <= 1'b1;
      if (go_req) begin
        wr_ni <= phase || mode == 2'b01;
        pair  <= phase || mode == 2'b10;
      end
      if (done) begin
        txn_cnt <= txn_cnt + 1'b1;
        if (!wr_ni) begin
          dataW <= dataW + 1'b1;
          phase <= pair;
          if (!pair) address <= addr_nx;
        end else begin
          address <= addr_nx;
          phase   <= 1'b0;
          if (phase && dataR != dataW - 1'b1) begin
            err_flag <= 1'b1;
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
          end
        end
      end
    end
endmodule

// File: tb/tb_bus_client_gen.sv
// tb_bus_client_gen: directed scoreboard bench for bus_client_gen
module tb_bus_client_gen;
  logic clk = 0, reset = 0, en = 0, ack = 0;
  logic [1:0] mode = 2'b00;
  logic [3:0] address;
  logic rq, wr_ni, err_flag, timeout;
  logic [7:0] dataW, err_cnt;
  logic [7:0] dataR = 8'h00;
  logic [15:0] txn_cnt;
  typedef struct {logic [3:0] addr; logic wr; logic [7:0] data;} exp_t;
  exp_t q[$];
  logic [7:0] mem [16];
  int n_chk = 0, n_pass = 0, n_fail = 0;
  bus_client_gen #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .ADDR_SPACE_BEGINNING(0), .ADDR_SPACE_END(3),
    .REQUEST_DELAY(10), .DATA_SEED(1), .TIMEOUT(64), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .address(address), .rq(rq), .ack(ack),
    .wr_ni(wr_ni), .dataW(dataW), .dataR(dataR), .txn_cnt(txn_cnt), .err_cnt(err_cnt),
    .err_flag(err_flag), .timeout(timeout));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    assert (got === want) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask
  function automatic void push(input logic [3:0] a, input logic w, input logic [7:0] d);
    q.push_back('{addr: a, wr: w, data: d});
  endfunction
  task automatic wait_rq(output bit ok);
    int w = 0;
    while (!rq && w < 300) begin
      @(negedge clk);
      w++;
    end
    ok = rq;
  endtask
  task automatic do_reset();
    reset = 0;
    repeat (2) @(negedge clk);
    reset = 1;
    @(negedge clk);
    q.delete();
  endtask
  task automatic serve(input int lat, input bit bad, input bit drop);
    exp_t e;
    bit ok;
    wait_rq(ok);
    chk("rq_rise", 32'(rq), 1);
    if (!ok) return;
    e = q.pop_front();
    chk("addr", 32'(address), 32'(e.addr));
    chk("wr_ni", 32'(wr_ni), 32'(e.wr));
    if (!e.wr) chk("dataW", 32'(dataW), 32'(e.data));
    if (drop) en = 0;
    repeat (lat - 1) @(negedge clk);
    chk("rq_hold", 32'(rq), 1);
    if (!e.wr) mem[e.addr] = e.data;
    dataR = bad ? 8'hFF : mem[e.addr];
    ack = 1;
    @(negedge clk);
    ack = 0;
    chk("rq_drop", 32'(rq), 0);
  endtask
  initial begin
    bit ok, seen;
    int n;
    do_reset();
    repeat (50) @(negedge clk);
    chk("rst_rq", 32'(rq), 0);
    chk("rst_addr", 32'(address), 0);
    chk("rst_dataW", 32'(dataW), 1);
    chk("rst_txn", 32'(txn_cnt), 0);
    chk("rst_err", 32'(err_cnt), 0);
    chk("rst_flags", {30'd0, err_flag, timeout}, 0);
    mode = 2'b00;
    ack = 1;
    en = 1;
    repeat (10) @(negedge clk);
    chk("first_rq_early", 32'(rq), 0);
    chk("ack_outside_req", 32'(txn_cnt), 0);
    ack = 0;
    @(negedge clk);
    chk("first_rq_edge11", 32'(rq), 1);
    for (int i = 0; i < 5; i++) push(4'((i % 4)), 1'b0, 8'(i + 1));
    for (int i = 0; i < 5; i++) serve(2, 0, 0);
    en = 0;
    chk("walk_txn", 32'(txn_cnt), 5);
    repeat (20) @(negedge clk);
    chk("walk_idle_rq", 32'(rq), 0);
    chk("walk_addr_wrap", 32'(address), 1);
    chk("walk_dataW", 32'(dataW), 6);
    do_reset();
    mode = 2'b10;
    en = 1;
    push(0, 0, 1); push(0, 1, 0); push(1, 0, 2); push(1, 1, 0);
    for (int i = 0; i < 4; i++) serve(1, 0, 0);
    chk("wr_rd_err0", 32'(err_cnt), 0);
    chk("wr_rd_flag0", 32'(err_flag), 0);
    push(2, 0, 3); push(2, 1, 0);
    serve(1, 0, 0);
    serve(1, 1, 0);
    en = 0;
    chk("wr_rd_err1", 32'(err_cnt), 1);
    chk("wr_rd_flag1", 32'(err_flag), 1);
    chk("wr_rd_txn", 32'(txn_cnt), 6);
    repeat (15) @(negedge clk);
    do_reset();
    mode = 2'b00;
    en = 1;
    wait_rq(ok);
    chk("to_rq", 32'(rq), 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rq && n < 200);
    chk("to_cycles", 32'(n), 64);
    chk("to_flag", 32'(timeout), 1);
    chk("to_txn", 32'(txn_cnt), 0);
    push(0, 0, 1);
    serve(1, 0, 0);
    chk("retry_txn", 32'(txn_cnt), 1);
    en = 0;
    chk("to_sticky", 32'(timeout), 1);
    repeat (15) @(negedge clk);
    en = 1;
    push(1, 0, 2);
    serve(5, 0, 1);
    chk("endrop_txn", 32'(txn_cnt), 2);
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      seen |= rq;
    end
    chk("endrop_no_rq", 32'(seen), 0);
    en = 1;
    wait_rq(ok);
    chk("ar_rq", 32'(rq), 1);
    #2 reset = 0;
    #1 chk("ar_rq_drop", 32'(rq), 0);
    chk("ar_txn", 32'(txn_cnt), 0);
    chk("ar_timeout", 32'(timeout), 0);
    @(negedge clk);
    reset = 1;
    q.delete();
    push(0, 0, 1);
    serve(1, 0, 0);
    chk("ar_restart_txn", 32'(txn_cnt), 1);
    en = 0;
    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
